// File: rtl/membus_arbiter_pkg.sv
// MemBus request/response types and the arbiter state encoding shared by the memory-side blocks.
package meminf;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
    } MemBusReq;

    typedef struct packed {
        logic        valid;
        logic        error;
        logic [31:0] addr;
        logic [31:0] rdata;
    } MemBusResp;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_I,
        ARB_WAIT_D
    } ArbState;

    // Grant encoding: 1 = data side, 0 = instruction side.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/membus_arbiter.sv
// Purpose: two-master (icache/dcache) to one-slave MemBus arbiter, one outstanding transaction.
// Latency: request passes through in 0 cycles; response forwarded combinationally to its issuer.
// Backpressure: mreq_ready relayed to the granted master only; a stalled grant is locked. Option: ARB_ROUND_ROBIN_EN.
module membus_arbiter
    import meminf::*;
#(
    parameter logic DEFAULT_PRIO = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    input  MemBusReq  ireq_in,
    output logic      ireq_ready,
    output MemBusResp iresp_out,
    input  MemBusReq  dreq_in,
    output logic      dreq_ready,
    output MemBusResp dresp_out,
    output MemBusReq  mreq_out,
    input  logic      mreq_ready,
    input  MemBusResp mresp_in
);

    ArbState state_q, state_d;
    logic    lock_q, lock_d;
    logic    lock_gnt_q, lock_gnt_d;
    logic    any_vld;
    logic    gnt;
    logic    tie_gnt;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
    logic rr_armed_q, rr_armed_d;

    // Until something has been accepted, the first tie falls back to DEFAULT_PRIO.
    assign tie_gnt = rr_armed_q ? ~last_grant_q : DEFAULT_PRIO;
`else
    assign tie_gnt = DEFAULT_PRIO;
`endif

    always_comb begin
        any_vld = ireq_in.valid | dreq_in.valid;
        if (lock_q) begin
            gnt = lock_gnt_q;
        end else if (ireq_in.valid && dreq_in.valid) begin
            gnt = tie_gnt;
        end else begin
            gnt = dreq_in.valid ? GNT_D : GNT_I;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        lock_gnt_d = lock_gnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
        rr_armed_d   = rr_armed_q;
`endif
        mreq_out       = (gnt == GNT_D) ? dreq_in : ireq_in;
        mreq_out.valid = 1'b0;
        mreq_out.ready = 1'b0;
        ireq_ready     = 1'b0;
        dreq_ready     = 1'b0;
        iresp_out       = mresp_in;
        dresp_out       = mresp_in;
        iresp_out.valid = 1'b0;
        dresp_out.valid = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (any_vld) begin
                    mreq_out.valid = 1'b1;
                    ireq_ready     = (gnt == GNT_I) && mreq_ready;
                    dreq_ready     = (gnt == GNT_D) && mreq_ready;
                    if (mreq_ready) begin
                        state_d = (gnt == GNT_D) ? ARB_WAIT_D : ARB_WAIT_I;
                        lock_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d = gnt;
                        rr_armed_d   = 1'b1;
`endif
                    end else begin
                        lock_d     = 1'b1;
                        lock_gnt_d = gnt;
                    end
                end
            end
            ARB_WAIT_I: begin
                iresp_out.valid = mresp_in.valid;
                if (mresp_in.valid) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT_D: begin
                dresp_out.valid = mresp_in.valid;
                if (mresp_in.valid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Handshake bits are held low for the whole time reset is asserted.
        if (!reset) begin
            mreq_out.valid  = 1'b0;
            ireq_ready      = 1'b0;
            dreq_ready      = 1'b0;
            iresp_out.valid = 1'b0;
            dresp_out.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            lock_q     <= 1'b0;
            lock_gnt_q <= GNT_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= DEFAULT_PRIO;
            rr_armed_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
            rr_armed_q   <= rr_armed_d;
`endif
        end
    end

endmodule
